// File: rtl/sigma_delta_dac_sequencer.sv
// sigma_delta_dac_sequencer: buffers PCM samples and feeds them to a sigma-delta
// modulator at a programmable tick rate, with soft-mute ramp and underflow tracking.
// Ports:
//   clk, rst_n        - clock, synchronous active-low reset
//   enable, osr, mute - run enable, tick period (0 treated as 1), soft-mute request
//   s_data/s_valid/s_ready - sample input handshake
//   din/din_valid     - registered sample and one-cycle update strobe to the modulator
//   fifo_level        - buffer occupancy
//   underflow/underflow_cnt - empty-buffer tick pulse and its saturating count
//   state             - IDLE=0, RUN=1, RAMP=2, MUTED=3
module sigma_delta_dac_sequencer #(
   parameter int FIFO_DEPTH = 8,
   parameter int RAMP_STEP  = 256
) (
   input  logic                          clk,
   input  logic                          rst_n,
   input  logic                          enable,
   input  logic [9:0]                    osr,
   input  logic                          mute,
   input  logic [15:0]                   s_data,
   input  logic                          s_valid,
   output logic                          s_ready,
   output logic [15:0]                   din,
   output logic                          din_valid,
   output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
   output logic                          underflow,
   output logic [7:0]                    underflow_cnt,
   output logic [1:0]                    state
);
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] RUN   = 2'd1;
   localparam logic [1:0] RAMP  = 2'd2;
   localparam logic [1:0] MUTED = 2'd3;
   localparam logic [AW:0] FULL = FIFO_DEPTH[AW:0];
   localparam logic [16:0] STEP17 = 17'(RAMP_STEP);
   localparam logic [15:0] STEP16 = 16'(RAMP_STEP);
   logic [15:0]   mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [9:0]    cnt, per, per_osr;
   logic          tick, push, pop;
   logic [16:0]   mag;
   logic [15:0]   ramped;
   // per holds the period of the current tick interval so an osr change only lands at a wrap
   assign per_osr = osr == 10'd0 ? 10'd1 : osr;
   assign tick    = state != IDLE && enable && cnt == per - 10'd1;
   assign s_ready = state != IDLE && fifo_level != FULL;
   assign push    = s_valid && s_ready;
   assign pop     = tick && fifo_level != '0;
   // 17-bit magnitude keeps -32768 representable
   assign mag     = din[15] ? -{1'b1, din} : {1'b0, din};
   assign ramped  = mag <= STEP17 ? 16'd0 : din[15] ? din + STEP16 : din - STEP16;
   always_ff @(posedge clk)
      if (push) mem[wr_ptr] <= s_data;
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state         <= IDLE;
         cnt           <= '0;
         per           <= 10'd1;
         wr_ptr        <= '0;
         rd_ptr        <= '0;
         fifo_level    <= '0;
         din           <= '0;
         din_valid     <= 1'b0;
         underflow     <= 1'b0;
         underflow_cnt <= '0;
      end else begin
         din_valid <= tick;
         underflow <= tick && state == RUN && fifo_level == '0;
         if (!enable || state == IDLE || tick) begin
            cnt <= '0;
            per <= per_osr;
         end else
            cnt <= cnt + 10'd1;
         if (!enable) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
         end else begin
            wr_ptr     <= wr_ptr + AW'(push);
            rd_ptr     <= rd_ptr + AW'(pop);
            fifo_level <= fifo_level + (AW+1)'(push) - (AW+1)'(pop);
         end
         if (tick)
            din <= state == RUN ? (pop ? mem[rd_ptr] : din) : state == RAMP ? ramped : 16'd0;
         if (tick && state == RUN && fifo_level == '0 && underflow_cnt != 8'hFF)
            underflow_cnt <= underflow_cnt + 8'd1;
         state <= !enable ? IDLE :
                  state == IDLE ? RUN :
                  state == RUN ? (mute ? RAMP : RUN) :
                  !mute ? RUN :
                  (state == RAMP && tick && ramped == 16'd0) ? MUTED : state;
      end
   end
endmodule
